ospfb_phasecomp: RTL

Phase-compensation stage of the oversampled PFB. It sits between the polyphase FIR PE array and the parallel FFT. It buffers each M-sample filtered frame in a ping-pong RAM and replays it circularly rotated by (n·D) mod M, which removes the phase progression caused by decimating by D < M. Framing, shift sequence and handshakes are fully defined here so the FFT sees frame-aligned, correctly rotated data.

---
 rtl/ospfb_phasecomp.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ospfb_phasecomp.sv
// Phase compensation for the oversampled PFB: ping-pong frame buffer replayed with a
// circular rotation of (n*D) mod M so the FFT sees phase-aligned frames.
//   state  | meaning
//   IDLE   | waiting for full[rbank]
//   START  | issue the first read at (B - sh) mod B
//   STREAM | issue the remaining beats, read address wrapping B-1 -> 0
module ospfb_phasecomp #(
  parameter int WIDTH        = 16,
  parameter int SAMP_PER_CLK = 2,
  parameter int FFT_LEN      = 128,
  parameter int DEC_FAC      = 96
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [SAMP_PER_CLK*WIDTH-1:0] s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic [SAMP_PER_CLK*WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          frame_err
);
  localparam int DW  = SAMP_PER_CLK*WIDTH;
  localparam int B   = FFT_LEN/SAMP_PER_CLK;
  localparam int DB  = DEC_FAC/SAMP_PER_CLK;
  localparam int AW  = (B > 1) ? $clog2(B) : 1;
  localparam int AW1 = AW + 1;
  localparam logic [AW:0]   B_W    = AW1'(B);
  localparam logic [AW:0]   DB_W   = AW1'(DB);
  localparam logic [AW-1:0] LAST_A = AW'(B-1);

  typedef enum logic [1:0] {IDLE, START, STREAM} state_t;

  state_t        state_q;
  logic [1:0]    full_q, full_d;
  logic          wbank_q, rbank_q, rel_bank_q, frame_err_q;
  logic [AW-1:0] wptr_q, raddr_q, bcnt_q, sh_q;
  logic [DW-1:0] mem_q [2][B];
  logic [DW:0]   skid_q [2];
  logic          skid_wp_q, skid_rp_q;
  logic [1:0]    skid_cnt_q;

  logic          wr_en, wr_last, issue, issue_last, pop, pop_last, out_vld;
  logic [AW-1:0] start_addr, issue_addr, next_addr, sh_next;
  logic [AW:0]   sh_sum;
  logic [DW:0]   skid_head;

  assign s_axis_tready = !full_q[wbank_q] && !rst;
  assign wr_en         = s_axis_tvalid && s_axis_tready;
  assign wr_last       = (wptr_q == LAST_A);

  assign skid_head     = skid_q[skid_rp_q];
  assign out_vld       = (skid_cnt_q != 2'd0) && !rst;
  assign m_axis_tvalid = out_vld;
  assign m_axis_tdata  = out_vld ? skid_head[DW-1:0] : '0;
  assign m_axis_tlast  = out_vld && skid_head[DW];
  assign frame_err     = frame_err_q && !rst;
  assign pop           = out_vld && m_axis_tready;
  assign pop_last      = pop && skid_head[DW];

  // A read lands in the skid on the same edge it is issued, so a free slot now is enough.
  assign issue      = ((state_q == START) || (state_q == STREAM)) && (skid_cnt_q != 2'd2);
  assign start_addr = (sh_q == '0) ? '0 : AW'(B_W - {1'b0, sh_q});
  assign issue_addr = (state_q == START) ? start_addr : raddr_q;
  assign issue_last = (state_q == STREAM) && (bcnt_q == LAST_A);
  assign next_addr  = (issue_addr == LAST_A) ? '0 : issue_addr + 1'b1;
  assign sh_sum     = {1'b0, sh_q} + DB_W;
  assign sh_next    = (sh_sum >= B_W) ? AW'(sh_sum - B_W) : sh_sum[AW-1:0];

  always_comb begin
    full_d = full_q;
    if (pop_last)          full_d[rel_bank_q] = 1'b0;
    if (wr_en && wr_last)  full_d[wbank_q]    = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wbank_q][wptr_q] <= s_axis_tdata;
    if (issue) skid_q[skid_wp_q] <= {issue_last, mem_q[rbank_q][issue_addr]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      full_q      <= '0;
      wbank_q     <= 1'b0;
      rbank_q     <= 1'b0;
      rel_bank_q  <= 1'b0;
      frame_err_q <= 1'b0;
      wptr_q      <= '0;
      raddr_q     <= '0;
      bcnt_q      <= '0;
      sh_q        <= '0;
      skid_wp_q   <= 1'b0;
      skid_rp_q   <= 1'b0;
      skid_cnt_q  <= '0;
    end else begin
      full_q <= full_d;
      if (wr_en) begin
        if (s_axis_tlast != wr_last) frame_err_q <= 1'b1;
        wptr_q <= wr_last ? '0 : wptr_q + 1'b1;
        if (wr_last) wbank_q <= ~wbank_q;
      end
      if (pop_last) rel_bank_q <= ~rel_bank_q;
      if (issue)    skid_wp_q  <= ~skid_wp_q;
      if (pop)      skid_rp_q  <= ~skid_rp_q;
      case ({issue, pop})
        2'b10:   skid_cnt_q <= skid_cnt_q + 2'd1;
        2'b01:   skid_cnt_q <= skid_cnt_q - 2'd1;
        default: skid_cnt_q <= skid_cnt_q;
      endcase
      case (state_q)
        IDLE: if (full_q[rbank_q]) state_q <= START;
        START: if (issue) begin
          raddr_q <= next_addr;
          bcnt_q  <= AW'(1);
          state_q <= STREAM;
        end
        STREAM: if (issue) begin
          raddr_q <= next_addr;
          bcnt_q  <= bcnt_q + 1'b1;
          // The bank is released only when its last beat leaves the skid (rel_bank_q).
          if (issue_last) begin
            rbank_q <= ~rbank_q;
            sh_q    <= sh_next;
            state_q <= full_q[~rbank_q] ? START : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
